// File: rtl/time_unit_counter_pkg.sv
// ---------------------------------------------------------------------------
// time_unit_counter_pkg
// Shared clock package: operating-mode encodings, the standard moduli of
// the clock digits, and a helper that splits a small binary value into
// two BCD digits for the 7-segment driver.
// ---------------------------------------------------------------------------
package time_unit_counter_pkg;

  // Operating modes as driven on the 2-bit mode input.
  typedef enum logic [1:0] {
    MODE_RUN       = 2'd0,
    MODE_SET_TIME  = 2'd1,
    MODE_SET_ALARM = 2'd2,
    MODE_RESERVED  = 2'd3
  } mode_e;

  // Moduli of the hour and minute/second digits.
  localparam int MOD_HOURS   = 24;
  localparam int MOD_MINUTES = 60;

  // Splits a value in 0..99 into {tens, ones}, four bits each.
  function automatic logic [7:0] to_bcd(input int unsigned value);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'(value / 10);
    ones = 4'(value % 10);
    return {tens, ones};
  endfunction

endpackage

// File: rtl/time_unit_counter_key_edge.sv
// ---------------------------------------------------------------------------
// key_edge
// Brings a raw active-low push-button into the clk domain and turns each
// press into a single-cycle pulse.
//   clk    : system clock
//   reset  : synchronous, active-high
//   key_n  : raw active-low button, asynchronous to clk
//   press  : one-cycle pulse on the 1->0 transition of the synchronised level
// ---------------------------------------------------------------------------
module key_edge (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic press
);

  logic sync1;
  logic sync2;
  logic hist;
  logic valid1;
  logic valid2;
  logic armed;

  // Two-flop synchroniser followed by a history flop for edge detection.
  // The synchroniser flops come out of reset in the released state, so a
  // key already held low at reset release would look like a fresh falling
  // edge. The valid pipeline marks when sync2 carries a real post-reset
  // sample, and detection stays disarmed until such a sample shows the key
  // released; a button held through reset therefore has to be let go and
  // pressed again before it counts.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      hist   <= 1'b1;
      valid1 <= 1'b0;
      valid2 <= 1'b0;
      armed  <= 1'b0;
    end else begin
      sync1  <= key_n;
      sync2  <= sync1;
      hist   <= sync2;
      valid1 <= 1'b1;
      valid2 <= valid1;
      if (valid2 && sync2) begin
        armed <= 1'b1;
      end
    end
  end

  assign press = armed & hist & ~sync2;

endmodule

// File: rtl/time_unit_counter.sv
// ---------------------------------------------------------------------------
// time_unit_counter
// One digit pair of a digital clock (hours, minutes or seconds) with an
// alarm setpoint, adjusted from two push-buttons.
//   clk, reset          : clock and synchronous active-high reset
//   cin                 : count tick from the next lower time unit
//   mode                : RUN / SET_TIME / SET_ALARM / reserved (acts as RUN)
//   key_up, key_dn      : raw active-low buttons, asynchronous to clk
//   qout                : current time value, 0..MODULUS-1
//   nout                : alarm setpoint, 0..MODULUS-1
//   cout                : carry tick to the next higher unit
//   match               : qout == nout
//   bcd_tens, bcd_ones  : decimal digits of qout
// ---------------------------------------------------------------------------
module time_unit_counter
  import time_unit_counter_pkg::*;
#(
  parameter int MODULUS    = MOD_HOURS,
  parameter int WIDTH      = 8,
  parameter int ALARM_INIT = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cin,
  input  logic [1:0]       mode,
  input  logic             key_up,
  input  logic             key_dn,
  output logic [WIDTH-1:0] qout,
  output logic [WIDTH-1:0] nout,
  output logic             cout,
  output logic             match,
  output logic [3:0]       bcd_tens,
  output logic [3:0]       bcd_ones
);

  // Reject illegal parameter sets when the design is elaborated.
  if (MODULUS < 2 || MODULUS > 100) begin : g_bad_modulus
    $error("time_unit_counter: MODULUS must lie in 2..100");
  end
  if (WIDTH < $clog2(MODULUS)) begin : g_bad_width
    $error("time_unit_counter: WIDTH too narrow for MODULUS");
  end
  if (ALARM_INIT < 0 || ALARM_INIT >= MODULUS) begin : g_bad_alarm_init
    $error("time_unit_counter: ALARM_INIT must be below MODULUS");
  end

  localparam logic [WIDTH-1:0] MAX_VAL   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ALARM_RST = WIDTH'(ALARM_INIT);

  mode_e            mode_s;
  logic             up_press;
  logic             dn_press;
  logic             step_up;
  logic             step_dn;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] n_next;
  logic [7:0]       bcd;

  // Wrap at MODULUS rather than at 2^WIDTH.
  function automatic logic [WIDTH-1:0] wrap_inc(input logic [WIDTH-1:0] v);
    return (v == MAX_VAL) ? '0 : v + WIDTH'(1);
  endfunction

  function automatic logic [WIDTH-1:0] wrap_dec(input logic [WIDTH-1:0] v);
    return (v == '0) ? MAX_VAL : v - WIDTH'(1);
  endfunction

  assign mode_s = mode_e'(mode);

  key_edge u_key_up (
    .clk   (clk),
    .reset (reset),
    .key_n (key_up),
    .press (up_press)
  );

  key_edge u_key_dn (
    .clk   (clk),
    .reset (reset),
    .key_n (key_dn),
    .press (dn_press)
  );

  // Simultaneous up and down presses cancel each other.
  assign step_up = up_press & ~dn_press;
  assign step_dn = dn_press & ~up_press;

  // Next-state selection: keys steer qout in SET_TIME and nout in
  // SET_ALARM; everywhere except SET_TIME the time keeps counting on cin.
  always_comb begin
    q_next = qout;
    n_next = nout;
    case (mode_s)
      MODE_SET_TIME: begin
        if (step_up) begin
          q_next = wrap_inc(qout);
        end else if (step_dn) begin
          q_next = wrap_dec(qout);
        end
      end
      MODE_SET_ALARM: begin
        if (cin) begin
          q_next = wrap_inc(qout);
        end
        if (step_up) begin
          n_next = wrap_inc(nout);
        end else if (step_dn) begin
          n_next = wrap_dec(nout);
        end
      end
      default: begin
        if (cin) begin
          q_next = wrap_inc(qout);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      qout <= '0;
      nout <= ALARM_RST;
    end else begin
      qout <= q_next;
      nout <= n_next;
    end
  end

  // The carry is suppressed while the time is being set by hand, so
  // adjusting this unit never disturbs the next higher one.
  assign cout = ~reset & cin & (qout == MAX_VAL) & (mode_s != MODE_SET_TIME);

  assign match = (qout == nout);

  assign bcd      = to_bcd(32'(qout));
  assign bcd_tens = bcd[7:4];
  assign bcd_ones = bcd[3:0];

endmodule

// File: tb/tb_time_unit_counter.sv
// ---------------------------------------------------------------------------
// tb_time_unit_counter
// Self-checking bench: a directed vector table and a randomized run with a
// behavioural model on a MODULUS=24 instance, plus hand-written sequences on
// a MODULUS=60 instance for reset with a held key and the 59->0 rollover.
// ---------------------------------------------------------------------------
module tb_time_unit_counter;
  import time_unit_counter_pkg::*;

  localparam int M_A     = MOD_HOURS;
  localparam int M_B     = MOD_MINUTES;
  localparam int INIT_B  = 7;
  localparam int N_RAND  = 3000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: hours, default parameters.
  logic       reset_a, cin_a, up_a, dn_a;
  logic [1:0] mode_a;
  logic [7:0] qout_a, nout_a;
  logic       cout_a, match_a;
  logic [3:0] tens_a, ones_a;

  // Instance B: minutes.
  logic       reset_b, cin_b, up_b, dn_b;
  logic [1:0] mode_b;
  logic [5:0] qout_b, nout_b;
  logic       cout_b, match_b;
  logic [3:0] tens_b, ones_b;

  time_unit_counter dut_a (
    .clk(clk), .reset(reset_a), .cin(cin_a), .mode(mode_a),
    .key_up(up_a), .key_dn(dn_a), .qout(qout_a), .nout(nout_a),
    .cout(cout_a), .match(match_a), .bcd_tens(tens_a), .bcd_ones(ones_a)
  );

  time_unit_counter #(.MODULUS(M_B), .WIDTH(6), .ALARM_INIT(INIT_B)) dut_b (
    .clk(clk), .reset(reset_b), .cin(cin_b), .mode(mode_b),
    .key_up(up_b), .key_dn(dn_b), .qout(qout_b), .nout(nout_b),
    .cout(cout_b), .match(match_b), .bcd_tens(tens_b), .bcd_ones(ones_b)
  );

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic [1:0] mode;
    logic       cin;
    logic       up;
    logic       dn;
    int         q;
    int         n;
    logic       cout;
    logic       match;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [1:0] m, input logic c, input logic u,
                              input logic d, input int q, input int n,
                              input logic co, input logic ma);
    vec_t v;
    v.mode = m; v.cin = c; v.up = u; v.dn = d;
    v.q = q; v.n = n; v.cout = co; v.match = ma;
    return v;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // Inputs change just after the falling edge; outputs are checked 1 ns later.
  task automatic applyStimulus(input logic rst, input logic c, input logic [1:0] m,
                               input logic u, input logic d);
    reset_a = rst; cin_a = c; mode_a = m; up_a = u; dn_a = d;
    #1;
  endtask

  task automatic driveB(input logic rst, input logic c, input logic [1:0] m,
                        input logic u, input logic d);
    reset_b = rst; cin_b = c; mode_b = m; up_b = u; dn_b = d;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Behavioural model of instance A: key samples taken at each edge since
  // the last reset; a press is a high sample followed by a low one, and it
  // takes effect two edges after the low sample.
  int mq, mn;
  bit up_hist[$];
  bit dn_hist[$];

  task automatic modelStep(input logic rst, input logic c, input logic [1:0] m,
                           input logic u, input logic d);
    bit pu, pd;
    int delta;
    if (rst) begin
      mq = 0; mn = 0;
      up_hist.delete(); dn_hist.delete();
      return;
    end
    pu = (up_hist.size() >= 3) && !up_hist[up_hist.size()-2] && up_hist[up_hist.size()-3];
    pd = (dn_hist.size() >= 3) && !dn_hist[dn_hist.size()-2] && dn_hist[dn_hist.size()-3];
    up_hist.push_back(u);
    dn_hist.push_back(d);
    if (up_hist.size() > 4) void'(up_hist.pop_front());
    if (dn_hist.size() > 4) void'(dn_hist.pop_front());
    delta = int'(pu) - int'(pd);
    if (m == 2'd1) begin
      mq = (mq + delta + M_A) % M_A;
    end else begin
      if (c) mq = (mq + 1) % M_A;
      if (m == 2'd2) mn = (mn + delta + M_A) % M_A;
    end
  endtask

  task automatic checkModel(input logic rst, input logic c, input logic [1:0] m);
    int exp_cout;
    exp_cout = (!rst && c && mq == M_A - 1 && m != 2'd1) ? 1 : 0;
    checkOutput("rand qout",  int'(qout_a),  mq);
    checkOutput("rand nout",  int'(nout_a),  mn);
    checkOutput("rand cout",  int'(cout_a),  exp_cout);
    checkOutput("rand match", int'(match_a), (mq == mn) ? 1 : 0);
    checkOutput("rand tens",  int'(tens_a),  mq / 10);
    checkOutput("rand ones",  int'(ones_a),  mq % 10);
  endtask

  initial begin
    logic       r_rst, r_cin, r_up, r_dn;
    logic [1:0] r_mode;

    reset_a = 1'b1; cin_a = 1'b0; mode_a = 2'd0; up_a = 1'b1; dn_a = 1'b1;
    reset_b = 1'b1; cin_b = 1'b0; mode_b = 2'd0; up_b = 1'b1; dn_b = 1'b1;

    // Directed table for instance A, one record per clock edge.
    vecs.push_back(mk(2'd1, 1, 1, 1,  0,  0, 0, 1));
    vecs.push_back(mk(2'd1, 1, 1, 0,  0,  0, 0, 1));
    vecs.push_back(mk(2'd1, 0, 1, 0,  0,  0, 0, 1));
    vecs.push_back(mk(2'd1, 0, 1, 0,  0,  0, 0, 1));
    vecs.push_back(mk(2'd1, 1, 1, 0, 23,  0, 0, 0));
    vecs.push_back(mk(2'd1, 0, 1, 0, 23,  0, 0, 0));
    vecs.push_back(mk(2'd0, 0, 1, 1, 23,  0, 0, 0));
    vecs.push_back(mk(2'd0, 1, 1, 1, 23,  0, 1, 0));
    vecs.push_back(mk(2'd0, 0, 1, 1,  0,  0, 0, 1));
    vecs.push_back(mk(2'd2, 0, 0, 1,  0,  0, 0, 1));
    vecs.push_back(mk(2'd2, 1, 0, 1,  0,  0, 0, 1));
    vecs.push_back(mk(2'd2, 0, 0, 1,  1,  0, 0, 0));
    vecs.push_back(mk(2'd2, 0, 1, 1,  1,  1, 0, 1));
    vecs.push_back(mk(2'd2, 0, 0, 0,  1,  1, 0, 1));
    vecs.push_back(mk(2'd2, 0, 0, 0,  1,  1, 0, 1));
    vecs.push_back(mk(2'd2, 0, 0, 0,  1,  1, 0, 1));
    vecs.push_back(mk(2'd0, 0, 1, 1,  1,  1, 0, 1));
    vecs.push_back(mk(2'd2, 0, 1, 0,  1,  1, 0, 1));
    vecs.push_back(mk(2'd2, 0, 1, 0,  1,  1, 0, 1));
    vecs.push_back(mk(2'd2, 0, 1, 0,  1,  1, 0, 1));
    vecs.push_back(mk(2'd2, 0, 1, 0,  1,  0, 0, 0));
    vecs.push_back(mk(2'd2, 0, 1, 1,  1,  0, 0, 0));
    vecs.push_back(mk(2'd2, 0, 1, 0,  1,  0, 0, 0));
    vecs.push_back(mk(2'd2, 0, 1, 0,  1,  0, 0, 0));
    vecs.push_back(mk(2'd2, 0, 1, 0,  1,  0, 0, 0));
    vecs.push_back(mk(2'd0, 0, 1, 1,  1, 23, 0, 0));

    // Reset both instances.
    @(negedge clk);
    applyStimulus(1, 0, 2'd0, 1, 1);
    driveB(1, 0, 2'd0, 1, 1);
    tick();
    tick();
    checkOutput("reset qout_a", int'(qout_a), 0);
    checkOutput("reset nout_a", int'(nout_a), 0);
    checkOutput("reset qout_b", int'(qout_b), 0);
    checkOutput("reset nout_b", int'(nout_b), INIT_B);

    foreach (vecs[i]) begin
      applyStimulus(0, vecs[i].cin, vecs[i].mode, vecs[i].up, vecs[i].dn);
      checkOutput($sformatf("vec%0d qout", i),  int'(qout_a),  vecs[i].q);
      checkOutput($sformatf("vec%0d nout", i),  int'(nout_a),  vecs[i].n);
      checkOutput($sformatf("vec%0d cout", i),  int'(cout_a),  int'(vecs[i].cout));
      checkOutput($sformatf("vec%0d match", i), int'(match_a), int'(vecs[i].match));
      checkOutput($sformatf("vec%0d tens", i),  int'(tens_a),  vecs[i].q / 10);
      checkOutput($sformatf("vec%0d ones", i),  int'(ones_a),  vecs[i].q % 10);
      tick();
    end

    // Instance B: count to 37, then reset with key_up held low.
    for (int i = 0; i < 37; i++) begin
      driveB(0, 1, 2'd0, 1, 1);
      tick();
    end
    driveB(0, 0, 2'd0, 1, 1);
    checkOutput("b count qout", int'(qout_b), 37);
    checkOutput("b count tens", int'(tens_b), 3);
    checkOutput("b count ones", int'(ones_b), 7);
    driveB(0, 0, 2'd0, 0, 1);
    tick();
    driveB(1, 1, 2'd0, 0, 1);
    tick();
    tick();
    checkOutput("b held-reset qout", int'(qout_b), 0);
    checkOutput("b held-reset nout", int'(nout_b), INIT_B);
    checkOutput("b held-reset cout", int'(cout_b), 0);
    for (int i = 0; i < 10; i++) begin
      driveB(0, 0, 2'd1, 0, 1);
      tick();
    end
    checkOutput("b held-key no press", int'(qout_b), 0);
    for (int i = 0; i < 4; i++) begin
      driveB(0, 0, 2'd1, 1, 1);
      tick();
    end
    checkOutput("b released qout", int'(qout_b), 0);
    driveB(0, 0, 2'd1, 0, 1);
    tick();
    tick();
    checkOutput("b press latency early", int'(qout_b), 0);
    tick();
    checkOutput("b press latency", int'(qout_b), 1);
    for (int i = 0; i < 5; i++) tick();
    checkOutput("b press no repeat", int'(qout_b), 1);

    // Instance B: count 1 -> 59, then roll over.
    for (int i = 0; i < 58; i++) begin
      driveB(0, 1, 2'd0, 1, 1);
      tick();
    end
    driveB(0, 0, 2'd0, 1, 1);
    checkOutput("b 59 qout", int'(qout_b), 59);
    checkOutput("b 59 tens", int'(tens_b), 5);
    checkOutput("b 59 ones", int'(ones_b), 9);
    checkOutput("b 59 cout idle", int'(cout_b), 0);
    driveB(0, 1, 2'd0, 1, 1);
    checkOutput("b 59 cout", int'(cout_b), 1);
    tick();
    driveB(0, 0, 2'd0, 1, 1);
    checkOutput("b wrap qout", int'(qout_b), 0);
    checkOutput("b wrap cout", int'(cout_b), 0);
    checkOutput("b wrap tens", int'(tens_b), 0);
    checkOutput("b wrap ones", int'(ones_b), 0);

    // Randomized run on instance A against the model.
    r_up = 1; r_dn = 1; r_mode = 2'd0;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1, 0, 2'd0, 1, 1);
      tick();
      modelStep(1, 0, 2'd0, 1, 1);
    end
    for (int i = 0; i < N_RAND; i++) begin
      r_rst = ($urandom_range(0, 299) == 0);
      r_cin = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 9) == 0) r_mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) r_up = ~r_up;
      if ($urandom_range(0, 5) == 0) r_dn = ~r_dn;
      applyStimulus(r_rst, r_cin, r_mode, r_up, r_dn);
      checkModel(r_rst, r_cin, r_mode);
      tick();
      modelStep(r_rst, r_cin, r_mode, r_up, r_dn);
    end
    applyStimulus(0, 0, 2'd0, 1, 1);
    checkModel(0, 0, 2'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/time_unit_counter.md
TIME_UNIT_COUNTER -- requirements
Module: time_unit_counter

Interface
REQ-001 Parameter MODULUS, default 24: count range 0..MODULUS-1; legal range 2..100.
REQ-002 Parameter WIDTH, default 8: width of qout/nout; SHALL be >= clog2(MODULUS).
REQ-003 Parameter ALARM_INIT, default 0: reset value of nout; SHALL be < MODULUS.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 cin  input  1  one-cycle count-enable tick from the lower time unit.
REQ-007 mode  input  2  operating mode: RUN=0, SET_TIME=1, SET_ALARM=2, 3 reserved.
REQ-008 key_up  input  1  raw active-low push-button, asynchronous to clk.
REQ-009 key_dn  input  1  raw active-low push-button, asynchronous to clk.
REQ-010 qout  output  WIDTH  current time value, binary.
REQ-011 nout  output  WIDTH  alarm setpoint, binary.
REQ-012 cout  output  1  carry tick to the next higher unit.
REQ-013 match  output  1  high while qout equals nout.
REQ-014 bcd_tens, bcd_ones  output  4 each  BCD digits of qout for the 7-segment driver.

Function
REQ-015 Each key SHALL pass through a 2-flop synchroniser plus a history flop; a press is a single-cycle pulse on the 1->0 transition of the synchronised level.
REQ-016 A key falling before edge k SHALL produce its press pulse in the cycle after edge k+1, so the target register updates at edge k+2.
REQ-017 A key held low SHALL produce exactly one press; no auto-repeat.
REQ-018 RUN (and reserved mode 3): qout increments on each cycle with cin=1, with 0 following MODULUS-1; key presses ignored.
REQ-019 SET_TIME: cin ignored, qout frozen except for key_up press (+1, wrap MODULUS-1->0) and key_dn press (-1, wrap 0->MODULUS-1).
REQ-020 SET_ALARM: key presses adjust nout with the same +1/-1 wrap rules; qout keeps counting on cin as in RUN.
REQ-021 Press on key_up and key_dn in the same cycle SHALL leave the target register unchanged.
REQ-022 nout changes only in SET_ALARM; it holds its value in all other modes.
REQ-023 cout SHALL be combinational: cin AND qout==MODULUS-1 AND mode is RUN, SET_ALARM or reserved; 0 in SET_TIME and during reset.
REQ-024 match SHALL be combinational qout==nout, in every mode.
REQ-025 bcd_tens = qout/10, bcd_ones = qout mod 10, combinational; values from 0 to MODULUS-1 only.
REQ-026 A mode change SHALL take effect on the same edge it is sampled; a press pulse in flight applies under the mode present at that edge.
REQ-027 Arithmetic SHALL be modular in MODULUS, never in 2^WIDTH; qout and nout never exceed MODULUS-1.

Reset
REQ-028 While reset=1 at a rising edge: qout=0, nout=ALARM_INIT, synchroniser and history flops=1 (released); reset overrides cin and keys.
REQ-029 A key held low through reset release SHALL NOT generate a press until it is released and pressed again.

Structure
REQ-030 Mode encodings (RUN, SET_TIME, SET_ALARM) SHALL live in the shared clock package; MODULUS values 24/60 are defined there as named constants.
REQ-031 Synchroniser and edge detect SHALL be one sub-module, key_edge, instantiated once per key.
REQ-032 Parameter legality (REQ-001..003) SHALL be checked at elaboration.

Verification
REQ-033 MODULUS=24, RUN, qout=23, cin=1 for one cycle -> cout=1 that cycle, qout=0 next edge, bcd_tens/bcd_ones = 0/0.
REQ-034 SET_TIME, qout=0, key_dn pressed once and held 50 cycles -> qout=23 exactly 2 edges after the synchronised fall, no further change.
REQ-035 SET_ALARM, nout=5, qout counting under cin every cycle -> qout advances while nout goes 5->6 on one key_up press; match pulses when qout=6.
REQ-036 SET_TIME, key_up and key_dn fall in the same cycle -> qout unchanged; cout stays 0 even with cin=1 and qout=23.
REQ-037 MODULUS=60, reset asserted with qout=37 and key_up held low -> qout=0, nout=ALARM_INIT; no press until key_up is released and pressed again.
REQ-038 MODULUS=60, qout=59 -> bcd_tens=5, bcd_ones=9; a cin in RUN gives qout=0 and cout=1.
